big_core_fabric_mux: RTL

//  Parametrised fabric port for a multi-core tile: connects NUM_CORES big_core_mem_wrap fabric interfaces to one tile fabric link.
//  - Egress: per-core FIFOs feed a round-robin arbiter and a valid/ready output register.
//  - Ingress: one registered stage steers each transaction to its target core by core-select bits.
//  - Sits between the per-core memory wraps and the tile-level fabric/router.

---
 rtl/big_core_fabric_mux.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/big_core_fabric_mux.sv
// Tile fabric port: per-core egress FIFOs, round-robin output register, registered ingress steering.
// Define BIG_CORE_FABRIC_STATS_EN to add saturating per-core sent/drop counters (StatSent/StatDrop).

module big_core_fabric_mux #(
   parameter  int NUM_CORES    = 2,
   parameter  int FIFO_DEPTH   = 4,
   parameter  int TRANS_W      = 128,
   parameter  int CORE_SEL_LSB = 0,
   localparam int SEL_W        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                              Clk,
   input  logic                              Rst,
   input  logic [NUM_CORES-1:0]              CoreOutValid,
   input  logic [NUM_CORES-1:0][TRANS_W-1:0] CoreOutData,
   output logic [NUM_CORES-1:0]              CoreOvf,
`ifdef BIG_CORE_FABRIC_STATS_EN
   output logic [NUM_CORES-1:0][31:0]        StatSent,
   output logic [NUM_CORES-1:0][31:0]        StatDrop,
`endif
   output logic                              FabOutValid,
   output logic [TRANS_W-1:0]                FabOutData,
   output logic [SEL_W-1:0]                  FabOutSrc,
   input  logic                              FabOutReady,
   input  logic                              FabInValid,
   input  logic [TRANS_W-1:0]                FabInData,
   output logic [NUM_CORES-1:0]              CoreInValid,
   output logic [TRANS_W-1:0]                CoreInData,
   output logic                              InMisroute
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = 1;

   typedef enum logic {IDLE, HOLD} state_t;

   state_t                 state, state_nxt;
   logic [TRANS_W-1:0]     mem [NUM_CORES][FIFO_DEPTH];
   logic [PTR_W:0]         wr_ptr [NUM_CORES];
   logic [PTR_W:0]         rd_ptr [NUM_CORES];
   logic [NUM_CORES-1:0]   empty, full, push, pop, drop;
   logic                   any_pending, pop_en;
   logic [SEL_W-1:0]       rr_ptr, winner;
   logic [SEL_W-1:0]       sel, target;
   logic                   in_range;

   // FIFO status; a pop frees a slot for a same-cycle push on a full FIFO
   always_comb begin
      for (int i = 0; i < NUM_CORES; i++) begin
         empty[i] = (wr_ptr[i] == rd_ptr[i]);
         full[i]  = (wr_ptr[i][PTR_W] != rd_ptr[i][PTR_W]) &&
                    (wr_ptr[i][PTR_W-1:0] == rd_ptr[i][PTR_W-1:0]);
         push[i]  = CoreOutValid[i] && (!full[i] || pop[i]);
         drop[i]  = CoreOutValid[i] && full[i] && !pop[i];
      end
      any_pending = |(~empty);
   end

   // Round-robin search starting at rr_ptr, wrapping at NUM_CORES
   always_comb begin
      logic [SEL_W:0] idx;
      logic           found;
      // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         idx = {1'b0, rr_ptr} + (SEL_W+1)'(k);
         if (idx >= (SEL_W+1)'(NUM_CORES)) idx = idx - (SEL_W+1)'(NUM_CORES);
         if (!found && !empty[idx[SEL_W-1:0]]) begin
            found  = 1'b1;
            winner = idx[SEL_W-1:0];
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!Rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_pending) state_nxt = HOLD;
         HOLD:    if (FabOutReady && !any_pending) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pop_en = any_pending && ((state == IDLE) || FabOutReady);
      pop    = '0;
      if (pop_en) pop[winner] = 1'b1;
   end

   assign FabOutValid = (state == HOLD);

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         for (int i = 0; i < NUM_CORES; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
         end
         CoreOvf <= '0;
      end else begin
         for (int i = 0; i < NUM_CORES; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
            if (drop[i]) CoreOvf[i] <= 1'b1;
         end
      end
   end

   // NOTE: FIFO storage has no reset; the pointers alone define which entries are live.
   always_ff @(posedge Clk) begin
      for (int i = 0; i < NUM_CORES; i++)
         if (push[i]) mem[i][wr_ptr[i][PTR_W-1:0]] <= CoreOutData[i];
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         FabOutData <= '0;
         FabOutSrc  <= '0;
         rr_ptr     <= '0;
      end else if (pop_en) begin
         FabOutData <= mem[winner][rd_ptr[winner][PTR_W-1:0]];
         FabOutSrc  <= winner;
         rr_ptr     <= (winner == SEL_W'(NUM_CORES-1)) ? '0 : winner + SEL_W'(1);
      end
   end

   // Ingress steering; a single core always receives regardless of the select field
   always_comb begin
      sel      = FabInData[CORE_SEL_LSB +: SEL_W];
      target   = (NUM_CORES == 1) ? '0 : sel;
      in_range = (NUM_CORES == 1) || ({1'b0, sel} < (SEL_W+1)'(NUM_CORES));
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         CoreInValid <= '0;
         CoreInData  <= '0;
         InMisroute  <= 1'b0;
      end else begin
         CoreInValid <= (FabInValid && in_range) ? (NUM_CORES'(1) << target) : '0;
         CoreInData  <= FabInData;
         if (FabInValid && !in_range) InMisroute <= 1'b1;
      end
   end

`ifdef BIG_CORE_FABRIC_STATS_EN
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         StatSent <= '0;
         StatDrop <= '0;
      end else begin
         if (FabOutValid && FabOutReady && (StatSent[FabOutSrc] != '1))
            StatSent[FabOutSrc] <= StatSent[FabOutSrc] + 32'd1;
         for (int i = 0; i < NUM_CORES; i++)
            if (drop[i] && (StatDrop[i] != '1)) StatDrop[i] <= StatDrop[i] + 32'd1;
      end
   end
`endif

endmodule
